// File: rtl/fifo_rd_skid_pkg.sv
// Shared types for valid/ready skid stages.
// The state encoding doubles as the number of entries currently held.
package fifo_rd_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fifo_rd_skid_stage.sv
// Drain stage behind a fall-through FIFO: turns empty/pop/data into a registered
// valid/ready stream through a two-entry skid buffer, and counts delivered beats.
module fifo_rd_skid_stage
    import fifo_rd_skid_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  drained_cnt_o,
    output logic                  idle_o
);

    skid_state_e           state_q;
    logic [DATA_WIDTH-1:0] entry_a_q;
    logic [DATA_WIDTH-1:0] entry_b_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  pop;
    logic                  fire;

    // Pop depends only on local state, so ready_i never reaches the FIFO.
    assign pop     = rst_ni & ~flush_i & ~fifo_empty_i & (state_q != TWO);
    assign valid_o = (state_q != EMPTY) & ~flush_i;
    assign fire    = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
        // NOTE: synchronous reset clears the data registers too, so data_o reads 0 after reset.
        if (!rst_ni) begin
            state_q   <= EMPTY;
            entry_a_q <= '0;
            entry_b_q <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (pop) begin
                        state_q   <= ONE;
                        entry_a_q <= fifo_data_i;
                    end
                end
                ONE: begin
                    if (pop && fire) begin
                        entry_a_q <= fifo_data_i;
                    end else if (pop) begin
                        state_q   <= TWO;
                        entry_b_q <= fifo_data_i;
                    end else if (fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        state_q   <= ONE;
                        entry_a_q <= entry_b_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Flush leaves the count alone; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (fire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign fifo_pop_o    = pop;
    assign data_o        = entry_a_q;
    assign occupancy_o   = state_q;
    assign drained_cnt_o = cnt_q;
    assign idle_o        = (state_q == EMPTY) & fifo_empty_i;

endmodule
